// File: rtl/alu_pkg.sv
// Shared ALU definitions: divider state encoding, sizing constants and the
// two's-complement helpers used for operand/result sign handling.
package alu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2
    } div_state_e;

    localparam int          DIV_WIDTH         = 32;
    localparam int          DIV_ITERS         = 32;
    localparam logic [31:0] DIV_ZERO_QUOTIENT = 32'hFFFF_FFFF;

    function automatic logic [31:0] twos_neg(input logic [31:0] value);
        return ~value + 32'd1;
    endfunction

    function automatic logic [31:0] cond_neg(input logic [31:0] value, input logic negate);
        logic [31:0] result;
        if (negate) begin
            result = twos_neg(value);
        end else begin
            result = value;
        end
        return result;
    endfunction

endpackage

// File: rtl/add_sub_33.sv
// 33-bit generate/propagate adder with conditional B inversion; sub doubles
// as carry-in so a + ~b + 1 forms the subtraction. Carry-out is dropped.
module add_sub_33
    import alu_pkg::*;
(
    input  logic [DIV_WIDTH:0] a,
    input  logic [DIV_WIDTH:0] b,
    input  logic               sub,
    output logic [DIV_WIDTH:0] sum
);

    logic [DIV_WIDTH:0]   b_eff;
    logic [DIV_WIDTH:0]   gen;
    logic [DIV_WIDTH:0]   prop;
    logic [DIV_WIDTH+1:0] carry;

    // carry lookahead recurrence over generate/propagate terms
    always_comb begin
        b_eff    = b ^ {(DIV_WIDTH + 1){sub}};
        gen      = a & b_eff;
        prop     = a ^ b_eff;
        carry    = '0;
        carry[0] = sub;
        for (int i = 0; i <= DIV_WIDTH; i++) begin
            carry[i+1] = gen[i] | (prop[i] & carry[i]);
        end
        sum = prop ^ carry[DIV_WIDTH:0];
    end

endmodule

// File: rtl/div_32bit_seq.sv
// Signed 32-bit non-restoring divider, one quotient bit per clock.
// Operates on magnitudes and restores signs in the FIX cycle.
module div_32bit_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam logic [5:0] LAST_ITER = 6'(DIV_ITERS - 1);

    div_state_e  state_r, state_s;
    logic [5:0]  cnt_r, cnt_s;
    logic [32:0] rem_r, rem_s;
    logic [31:0] q_r, q_s;
    logic [31:0] dvsr_r, dvsr_s;
    logic        neg_q_r, neg_q_s;
    logic        neg_rem_r, neg_rem_s;
    logic        busy_r, busy_s;
    logic        done_r, done_s;
    logic        dbz_r, dbz_s;
    logic [31:0] quotient_r, quotient_s;
    logic [31:0] remainder_r, remainder_s;

    logic [32:0] add_a_s;
    logic [32:0] add_b_s;
    logic        add_sub_s;
    logic [32:0] add_sum_s;
    logic [31:0] rem_fixed_s;

    // shared adder: shift-and-add/subtract in CALC, remainder add-back in FIX
    always_comb begin
        add_b_s = {1'b0, dvsr_r};
        if (state_r == ST_CALC) begin
            add_a_s   = {rem_r[31:0], q_r[31]};
            add_sub_s = ~rem_r[32];
        end else begin
            add_a_s   = rem_r;
            add_sub_s = 1'b0;
        end
    end

    add_sub_33 u_add_sub (
        .a   (add_a_s),
        .b   (add_b_s),
        .sub (add_sub_s),
        .sum (add_sum_s)
    );

    // a negative final partial remainder needs the divisor added back
    always_comb begin
        if (rem_r[32]) begin
            rem_fixed_s = add_sum_s[31:0];
        end else begin
            rem_fixed_s = rem_r[31:0];
        end
    end

    // next-state and datapath update
    always_comb begin
        state_s     = state_r;
        cnt_s       = cnt_r;
        rem_s       = rem_r;
        q_s         = q_r;
        dvsr_s      = dvsr_r;
        neg_q_s     = neg_q_r;
        neg_rem_s   = neg_rem_r;
        busy_s      = busy_r;
        done_s      = 1'b0;
        dbz_s       = dbz_r;
        quotient_s  = quotient_r;
        remainder_s = remainder_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    if (divisor == 32'd0) begin
                        quotient_s  = DIV_ZERO_QUOTIENT;
                        remainder_s = dividend;
                        dbz_s       = 1'b1;
                        done_s      = 1'b1;
                    end else begin
                        rem_s     = 33'd0;
                        q_s       = cond_neg(dividend, dividend[31]);
                        dvsr_s    = cond_neg(divisor, divisor[31]);
                        neg_q_s   = dividend[31] ^ divisor[31];
                        neg_rem_s = dividend[31];
                        cnt_s     = 6'd0;
                        dbz_s     = 1'b0;
                        busy_s    = 1'b1;
                        state_s   = ST_CALC;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_CALC: begin
                rem_s = add_sum_s;
                q_s   = {q_r[30:0], ~add_sum_s[32]};
                cnt_s = cnt_r + 6'd1;
                if (cnt_r == LAST_ITER) begin
                    state_s = ST_FIX;
                end else begin
                    state_s = ST_CALC;
                end
            end
            ST_FIX: begin
                quotient_s  = cond_neg(q_r, neg_q_r);
                remainder_s = cond_neg(rem_fixed_s, neg_rem_r);
                done_s      = 1'b1;
                busy_s      = 1'b0;
                state_s     = ST_IDLE;
            end
            default: begin
                busy_s  = 1'b0;
                state_s = ST_IDLE;
            end
        endcase
    end

    // state and result registers
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state_r     <= ST_IDLE;
            cnt_r       <= 6'd0;
            rem_r       <= 33'd0;
            q_r         <= 32'd0;
            dvsr_r      <= 32'd0;
            neg_q_r     <= 1'b0;
            neg_rem_r   <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            dbz_r       <= 1'b0;
            quotient_r  <= 32'd0;
            remainder_r <= 32'd0;
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            rem_r       <= rem_s;
            q_r         <= q_s;
            dvsr_r      <= dvsr_s;
            neg_q_r     <= neg_q_s;
            neg_rem_r   <= neg_rem_s;
            busy_r      <= busy_s;
            done_r      <= done_s;
            dbz_r       <= dbz_s;
            quotient_r  <= quotient_s;
            remainder_r <= remainder_s;
        end
    end

    assign busy        = busy_r;
    assign done        = done_r;
    assign quotient    = quotient_r;
    assign remainder   = remainder_r;
    assign div_by_zero = dbz_r;

endmodule

// File: tb/tb_div_32bit_seq.sv
// Directed-vector bench for div_32bit_seq: table of hand-computed results
// plus sequences for ignored start, clear mid-divide and back-to-back use.
module tb_div_32bit_seq;

    logic        clock = 1'b0;
    logic        clear;
    logic        start;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_by_zero;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string       name;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
        logic        dbz;
    } vec_t;

    vec_t vecs[13];

    div_32bit_seq dut (
        .clock       (clock),
        .clear       (clear),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_start(input logic [31:0] a, input logic [31:0] b);
        @(negedge clock);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clock);
        #1;
        start    = 1'b0;
        dividend = $urandom;
        divisor  = $urandom;
    endtask

    // sample 1 is just after the start edge; optional start pulse at pulse_at
    task automatic wait_done(input int pulse_at, output int lat, output int busy_low);
        lat      = 1;
        busy_low = 0;
        while (done !== 1'b1 && lat < 60) begin
            if (busy !== 1'b1) busy_low++;
            if (lat == pulse_at) begin
                @(negedge clock);
                start    = 1'b1;
                dividend = 32'd8;
                divisor  = 32'd2;
            end
            @(posedge clock);
            #1;
            start = 1'b0;
            lat++;
        end
    endtask

    initial begin
        int lat;
        int busy_low;
        int done_seen;
        logic [31:0] held_q;

        vecs[0]  = '{"100/7",      32'd100,        32'd7,          32'd14,         32'd2,          1'b0};
        vecs[1]  = '{"-100/7",     32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFF2,  32'hFFFF_FFFE,  1'b0};
        vecs[2]  = '{"7/-2",       32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1,          1'b0};
        vecs[3]  = '{"min/-1",     32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          1'b0};
        vecs[4]  = '{"3/10",       32'd3,          32'd10,         32'd0,          32'd3,          1'b0};
        vecs[5]  = '{"5/0",        32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5,          1'b1};
        vecs[6]  = '{"9/3",        32'd9,          32'd3,          32'd3,          32'd0,          1'b0};
        vecs[7]  = '{"-7/-2",      32'hFFFF_FFF9,  32'hFFFF_FFFE,  32'd3,          32'hFFFF_FFFF,  1'b0};
        vecs[8]  = '{"max/1",      32'h7FFF_FFFF,  32'd1,          32'h7FFF_FFFF,  32'd0,          1'b0};
        vecs[9]  = '{"-1/min",     32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          32'hFFFF_FFFF,  1'b0};
        vecs[10] = '{"min/2",      32'h8000_0000,  32'd2,          32'hC000_0000,  32'd0,          1'b0};
        vecs[11] = '{"-5/0",       32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFF,  32'hFFFF_FFFB,  1'b1};
        vecs[12] = '{"0/5",        32'd0,          32'd5,          32'd0,          32'd0,          1'b0};

        clear    = 1'b1;
        start    = 1'b0;
        dividend = 32'd0;
        divisor  = 32'd0;
        #1;
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset done", {31'd0, done}, 32'd0);
        check("reset quotient", quotient, 32'd0);
        check("reset remainder", remainder, 32'd0);
        check("reset dbz", {31'd0, div_by_zero}, 32'd0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        clear = 1'b0;

        for (int i = 0; i < 13; i++) begin
            do_start(vecs[i].a, vecs[i].b);
            wait_done(-1, lat, busy_low);
            check({vecs[i].name, " latency"}, 32'(lat), vecs[i].dbz ? 32'd1 : 32'd34);
            check({vecs[i].name, " busy gaps"}, 32'(busy_low), 32'd0);
            check({vecs[i].name, " busy at done"}, {31'd0, busy}, 32'd0);
            check({vecs[i].name, " quotient"}, quotient, vecs[i].q);
            check({vecs[i].name, " remainder"}, remainder, vecs[i].r);
            check({vecs[i].name, " dbz"}, {31'd0, div_by_zero}, {31'd0, vecs[i].dbz});
            @(posedge clock);
            #1;
            check({vecs[i].name, " done drop"}, {31'd0, done}, 32'd0);
            check({vecs[i].name, " hold"}, quotient, vecs[i].q);
        end

        // start pulsed mid-divide must be ignored
        do_start(32'hFFFF_FFF9, 32'hFFFF_FFFE);
        wait_done(5, lat, busy_low);
        check("ignored start latency", 32'(lat), 32'd34);
        check("ignored start quotient", quotient, 32'd3);
        check("ignored start remainder", remainder, 32'hFFFF_FFFF);
        done_seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clock);
            #1;
            if (done === 1'b1) done_seen++;
        end
        check("ignored start no second done", 32'(done_seen), 32'd0);

        // back-to-back: restart during the done cycle
        do_start(32'hFFFF_FF9C, 32'd7);
        wait_done(-1, lat, busy_low);
        check("b2b first latency", 32'(lat), 32'd34);
        check("b2b first quotient", quotient, 32'hFFFF_FFF2);
        @(negedge clock);
        check("b2b in done cycle", {31'd0, done}, 32'd1);
        start    = 1'b1;
        dividend = 32'd50;
        divisor  = 32'd5;
        @(posedge clock);
        #1;
        start    = 1'b0;
        dividend = 32'd0;
        divisor  = 32'd0;
        wait_done(-1, lat, busy_low);
        check("b2b second latency", 32'(lat), 32'd34);
        check("b2b second busy gaps", 32'(busy_low), 32'd0);
        check("b2b second quotient", quotient, 32'd10);
        check("b2b second remainder", remainder, 32'd0);

        // clear mid-divide discards the in-flight result
        do_start(32'd1000, 32'd3);
        held_q = quotient;
        for (int k = 1; k < 10; k++) begin
            if (k == 5) begin
                @(negedge clock);
                start    = 1'b1;
                dividend = 32'd8;
                divisor  = 32'd2;
            end
            @(posedge clock);
            #1;
            start = 1'b0;
        end
        check("pre-clear busy", {31'd0, busy}, 32'd1);
        check("pre-clear quotient held", quotient, held_q);
        @(negedge clock);
        clear = 1'b1;
        #1;
        check("clear busy", {31'd0, busy}, 32'd0);
        check("clear done", {31'd0, done}, 32'd0);
        check("clear quotient", quotient, 32'd0);
        check("clear remainder", remainder, 32'd0);
        check("clear dbz", {31'd0, div_by_zero}, 32'd0);
        @(negedge clock);
        clear = 1'b0;
        done_seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clock);
            #1;
            if (done === 1'b1 || busy === 1'b1) done_seen++;
        end
        check("clear discards result", 32'(done_seen), 32'd0);
        do_start(32'd1000, 32'd3);
        wait_done(-1, lat, busy_low);
        check("after clear latency", 32'(lat), 32'd34);
        check("after clear quotient", quotient, 32'd333);
        check("after clear remainder", remainder, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/div_32bit_seq.md
# div_32bit_seq

Multi-cycle signed 32-bit divider for the datapath ALU, the inverse-direction companion of the 32-bit carry-lookahead adder. It computes one quotient bit per clock by non-restoring add/subtract iteration and returns quotient (LO) and remainder (HI). It sits beside the adder and multiplier in the ALU and is driven by the control unit's DIV step with a start/done handshake.

## Interface
- WIDTH, 32, operand/result width; only 32 is supported and verified.
- clock  in  1  rising-edge clock.
- clear  in  1  asynchronous active-high reset.
- start  in  1  request a divide; sampled only in IDLE.
- dividend  in  32  signed two's-complement numerator, captured on the start edge.
- divisor  in  32  signed two's-complement denominator, captured on the start edge.
- busy  out  1  high while a divide is in progress.
- done  out  1  one-cycle pulse; results are valid from this cycle onward.
- quotient  out  32  signed quotient (to LO).
- remainder  out  32  signed remainder (to HI).
- div_by_zero  out  1  set with done when the divisor was 0; cleared on the next accepted start.

## Operation
- States: IDLE, CALC, FIX.
- IDLE, start=1, divisor≠0: capture |dividend|, |divisor| and both signs; clear partial remainder; load iteration count 0; go to CALC; busy=1.
- IDLE, start=1, divisor=0: go directly to the done cycle, staying in IDLE. Set quotient=32'hFFFF_FFFF, remainder=dividend, div_by_zero=1, busy stays 0.
- CALC: each cycle, shift {remainder,quotient} left by 1. If the partial remainder is ≥0, subtract the divisor; otherwise add it. The new quotient LSB = ~sign(new remainder). After 32 iterations, go to FIX.
- FIX: if the partial remainder is <0, add the divisor back. Negate the quotient if the operand signs differ. Negate the remainder if the dividend was negative. Register the results, pulse done, drop busy, and return to IDLE.
- Semantics: the quotient truncates toward zero, and the remainder takes the sign of the dividend. The identity dividend = quotient*divisor + remainder holds mod 2^32.
- Overflow: 32'h8000_0000 / 32'hFFFF_FFFF gives quotient=32'h8000_0000 and remainder=0. No flag is raised.
- start while busy is ignored. Operands may change freely after the start edge.
- quotient, remainder and div_by_zero hold their last values until the next accepted start.
- clear at any time forces IDLE and drives busy, done, quotient, remainder and div_by_zero to 0. An in-flight result is discarded.

## Timing
- Reset values: busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, state IDLE.
- Normal latency: with the start edge at N, busy is high after N. CALC runs on edges N+1..N+32 and FIX on N+33. done=1 and busy=0 during the cycle after N+33, and done returns to 0 after N+34.
- Divide-by-zero latency: done=1 during the cycle after the start edge N.
- start=1 in the same cycle as done is accepted, giving back-to-back operation with no idle gap.
- Internal add/subtract is 33 bits wide (sign plus magnitude). The carry-out is discarded, and there are no combinational paths from inputs to outputs.

## Structure
- Shared package alu_pkg holds:
  - the state encoding (IDLE, CALC, FIX);
  - DIV_WIDTH=32;
  - DIV_ITERS=32;
  - DIV_ZERO_QUOTIENT=32'hFFFF_FFFF.
- One sub-module: add_sub_33.
  - Built on the team's CLA adder with B conditionally inverted and Cin = subtract.
  - Used for the iteration step and for the FIX correction.
  - Sign negation reuses the same two's-complement helper, one instance per operand.

## Test plan
- 100 / 7: done exactly 34 cycles after start, quotient=14, remainder=2, div_by_zero=0, busy high for cycles 1..33.
- -100 / 7: quotient=32'hFFFF_FFF2 (-14), remainder=32'hFFFF_FFFE (-2). Then 7 / -2: quotient=32'hFFFF_FFFD (-3), remainder=1.
- 32'h8000_0000 / 32'hFFFF_FFFF: quotient=32'h8000_0000, remainder=0. Also 3 / 10: quotient=0, remainder=3.
- 5 / 0: done one cycle after start, div_by_zero=1, quotient=32'hFFFF_FFFF, remainder=5, busy never asserted. Then 9 / 3 clears div_by_zero and gives quotient=3.
- Start 1000 / 3, pulse start with 8 / 2 at cycle 5, then assert clear at cycle 10. The second start is ignored, and after clear all outputs are 0 with busy=0. A new 1000 / 3 then gives quotient=333, remainder=1.
- Back-to-back: reassert start during the done cycle with 50 / 5. The second done arrives 34 cycles later with quotient=10 and remainder=0.
